counter_sequencer: RTL and testbench

//  Synchronous controller for the lab counter datapath: owns a programmable mod-N up/down counter,

---
 rtl/counter_seq_pkg.sv | 5 +
 rtl/counter_seq_core.sv | 44 ++++
 rtl/counter_sequencer.sv | 104 ++++++++++
 tb/tb_counter_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: FSM state and command opcode types shared by the counter sequencer.
package counter_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    typedef enum logic [1:0] {OP_START, OP_PAUSE, OP_RESUME, OP_ABORT} op_t;
endpackage

// File: rtl/counter_seq_core.sv
// counter_seq_core: mod-M up/down counter with load, clear and step enable; emits wrap and tc.
module counter_seq_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] cfg_modulus,
    input  logic             cfg_down,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);
    logic [WIDTH-1:0] last_q, count_n;
    logic             down_q;

    // last_q holds M-1 modulo 2**WIDTH, so M=0 naturally becomes all ones
    assign tc   = down_q ? (count == '0) : (count == last_q);
    assign wrap = en & tc;

    always_comb begin
        count_n = clr  ? '0 :
                  load ? (cfg_down ? cfg_modulus - WIDTH'(1) : '0) :
                  !en  ? count :
                  tc   ? (down_q ? last_q : '0) :
                  down_q ? count - WIDTH'(1) : count + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            last_q <= '0;
            down_q <= 1'b0;
        end else begin
            count <= count_n;
            if (load) begin
                last_q <= cfg_modulus - WIDTH'(1);
                down_q <= cfg_down;
            end
        end
    end
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven FSM around a mod-M counter that stops after a set number of wraps.
// Define CNT_SEQ_SNAPSHOT_EN to add the snap output capturing count on accepted PAUSE/ABORT.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int WRAPS_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cfg_modulus,
    input  logic               cfg_down,
    input  logic [WRAPS_W-1:0] cfg_wraps,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef CNT_SEQ_SNAPSHOT_EN
    ,
    output logic [WIDTH-1:0]   snap
`endif
);
    state_t             state, state_n;
    logic [WRAPS_W-1:0] wraps_left, wraps_n;
    logic               load_q, err_n, acc, abort, load, term, step_wrap, final_wrap, en;

    assign acc        = cmd_valid & cmd_ready;
    assign abort      = acc & (cmd_op == OP_ABORT);
    assign load       = acc & (cmd_op == OP_START) & (state == IDLE || state == DONE);
    assign final_wrap = (state == RUN) & term & (wraps_left == WRAPS_W'(1));
    assign en         = (state == RUN) & (state_n == RUN);
    assign cmd_ready  = !load_q;
    assign tc         = (state == RUN) & term;
    assign busy       = (state == RUN) | (state == PAUSE);
    assign done       = state == DONE;

    // Final wrap wins over any non-abort command; the losing command is reported as an error
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        if (abort)
            state_n = IDLE;
        else if (final_wrap) begin
            state_n = DONE;
            err_n   = acc;
        end else if (acc) begin
            if (load)
                state_n = RUN;
            else if (cmd_op == OP_PAUSE && state == RUN)
                state_n = PAUSE;
            else if (cmd_op == OP_RESUME && state == PAUSE)
                state_n = RUN;
            else
                err_n = 1'b1;
        end
    end

    always_comb begin
        wraps_n = abort ? '0 :
                  load  ? cfg_wraps :
                  ((step_wrap || final_wrap) && wraps_left != '0) ? wraps_left - WRAPS_W'(1) :
                  wraps_left;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wraps_left <= '0;
            load_q     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            wraps_left <= wraps_n;
            load_q     <= acc & (cmd_op == OP_START);
            err        <= err_n;
        end
    end

`ifdef CNT_SEQ_SNAPSHOT_EN
    always_ff @(posedge clk) begin
        if (reset)
            snap <= '0;
        else if (acc && (cmd_op == OP_PAUSE || cmd_op == OP_ABORT))
            snap <= count;
    end
`endif

    counter_seq_core #(.WIDTH(WIDTH)) core (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .clr         (abort),
        .en          (en),
        .cfg_modulus (cfg_modulus),
        .cfg_down    (cfg_down),
        .count       (count),
        .tc          (term),
        .wrap        (step_wrap)
    );
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed, self-checking bench for counter_sequencer (WIDTH=4, WRAPS_W=8).
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    logic       clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cfg_down = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cfg_modulus = 4'd0;
    logic [7:0] cfg_wraps = 8'd0;
    logic [3:0] count;
    logic       cmd_ready, tc, busy, done, err;
`ifdef CNT_SEQ_SNAPSHOT_EN
    logic [3:0] snap;
`endif
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    counter_sequencer #(.WIDTH(4), .WRAPS_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cfg_modulus (cfg_modulus),
        .cfg_down    (cfg_down),
        .cfg_wraps   (cfg_wraps),
        .count       (count),
        .tc          (tc),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef CNT_SEQ_SNAPSHOT_EN
        ,
        .snap        (snap)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] m, input logic dn, input logic [7:0] w);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cfg_modulus = m;
        cfg_down    = dn;
        cfg_wraps   = w;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [3:0] c, input logic t, b, d, e, r);
        vectors++;
        assert ({count, tc, busy, done, err, cmd_ready} === {c, t, b, d, e, r}) else begin
            miscompares++;
            $error("FAIL %s: count=%0d tc=%b busy=%b done=%b err=%b rdy=%b, expected count=%0d tc=%b busy=%b done=%b err=%b rdy=%b",
                   tag, count, tc, busy, done, err, cmd_ready, c, t, b, d, e, r);
        end
    endtask

`ifdef CNT_SEQ_SNAPSHOT_EN
    task automatic chk_snap(input string tag, input logic [3:0] s);
        vectors++;
        assert (snap === s) else begin
            miscompares++;
            $error("FAIL %s: snap=%0d, expected %0d", tag, snap, s);
        end
    endtask
`endif

    initial begin
        logic [3:0] x;
        // 1: reset, then M=10 up with two wraps
        tick();
        tick();
        chk("reset", 4'd0, 0, 0, 0, 0, 1);
        reset = 1'b0;
        cmd(OP_START, 4'd10, 1'b0, 8'd2);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 10; i++) begin
                chk("t1_run", 4'(i), i == 9, 1, 0, 0, p != 0 || i != 0);
                tick();
            end
        chk("t1_done", 4'd9, 0, 0, 1, 0, 1);
        // 2: restart from DONE, M=0 down, free-run
        cmd(OP_START, 4'd0, 1'b1, 8'd0);
        for (int i = 0; i < 34; i++) begin
            x = 4'(15 - i);
            chk("t2_down", x, x == 4'd0, 1, 0, 0, i != 0);
            tick();
        end
        cmd(OP_ABORT, 4'd0, 1'b0, 8'd0);
        chk("t2_abort", 4'd0, 0, 0, 0, 0, 1);
        // 3: pause and resume, M=6 up
        cmd(OP_START, 4'd6, 1'b0, 8'd0);
        chk("t3_load", 4'd0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t3_run", 4'(i), 0, 1, 0, 0, 1);
        end
        cmd(OP_PAUSE, 4'd0, 1'b0, 8'd0);
        chk("t3_pause", 4'd3, 0, 1, 0, 0, 1);
`ifdef CNT_SEQ_SNAPSHOT_EN
        chk_snap("t3_snap", 4'd3);
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_hold", 4'd3, 0, 1, 0, 0, 1);
        end
        cmd(OP_RESUME, 4'd0, 1'b0, 8'd0);
        chk("t3_resume", 4'd3, 0, 1, 0, 0, 1);
        tick();
        chk("t3_r4", 4'd4, 0, 1, 0, 0, 1);
        tick();
        chk("t3_r5", 4'd5, 1, 1, 0, 0, 1);
        tick();
        chk("t3_r0", 4'd0, 0, 1, 0, 0, 1);
        // 4: abort beats final wrap
        cmd(OP_ABORT, 4'd0, 1'b0, 8'd0);
        chk("t4_idle", 4'd0, 0, 0, 0, 0, 1);
        cmd(OP_START, 4'd4, 1'b0, 8'd1);
        chk("t4_load", 4'd0, 0, 1, 0, 0, 0);
        tick();
        tick();
        tick();
        chk("t4_term", 4'd3, 1, 1, 0, 0, 1);
        cmd(OP_ABORT, 4'd0, 1'b0, 8'd0);
        chk("t4_abort", 4'd0, 0, 0, 0, 0, 1);
`ifdef CNT_SEQ_SNAPSHOT_EN
        chk_snap("t4_snap", 4'd3);
`endif
        tick();
        chk("t4_noerr", 4'd0, 0, 0, 0, 0, 1);
        // final wrap beats pause
        cmd(OP_START, 4'd4, 1'b0, 8'd1);
        tick();
        tick();
        tick();
        chk("fp_term", 4'd3, 1, 1, 0, 0, 1);
        cmd(OP_PAUSE, 4'd0, 1'b0, 8'd0);
        chk("fp_done", 4'd3, 0, 0, 1, 1, 1);
        tick();
        chk("fp_errclr", 4'd3, 0, 0, 1, 0, 1);
        // M=1: every cycle wraps
        cmd(OP_START, 4'd1, 1'b0, 8'd3);
        chk("m1_load", 4'd0, 1, 1, 0, 0, 0);
        tick();
        chk("m1_w2", 4'd0, 1, 1, 0, 0, 1);
        tick();
        chk("m1_w1", 4'd0, 1, 1, 0, 0, 1);
        tick();
        chk("m1_done", 4'd0, 0, 0, 1, 0, 1);
        // 5: illegal commands
        cmd(OP_ABORT, 4'd0, 1'b0, 8'd0);
        chk("t5_idle", 4'd0, 0, 0, 0, 0, 1);
        cmd(OP_RESUME, 4'd0, 1'b0, 8'd0);
        chk("t5_resume_err", 4'd0, 0, 0, 0, 1, 1);
        tick();
        chk("t5_errclr", 4'd0, 0, 0, 0, 0, 1);
        cmd(OP_START, 4'd10, 1'b0, 8'd0);
        chk("t5_load", 4'd0, 0, 1, 0, 0, 0);
        tick();
        chk("t5_run1", 4'd1, 0, 1, 0, 0, 1);
        cmd(OP_START, 4'd3, 1'b1, 8'd5);
        chk("t5_start_err", 4'd2, 0, 1, 0, 1, 0);
        tick();
        chk("t5_run3", 4'd3, 0, 1, 0, 0, 1);
        // 6: reset mid-run with a command in flight
        for (int i = 0; i < 4; i++) tick();
        chk("t6_at7", 4'd7, 0, 1, 0, 0, 1);
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_PAUSE;
        tick();
        chk("t6_reset", 4'd0, 0, 0, 0, 0, 1);
`ifdef CNT_SEQ_SNAPSHOT_EN
        chk_snap("t6_snap", 4'd0);
`endif
        reset     = 1'b0;
        cmd_valid = 1'b0;
        tick();
        chk("t6_after", 4'd0, 0, 0, 0, 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
